// File: rtl/music_sched_pkg.sv
// rtl/music_sched_pkg.sv - shared state encoding, track IDs and default timing for music_sched
package music_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

    localparam logic [1:0] TRK_WAKA  = 2'd0;
    localparam logic [1:0] TRK_GHOST = 2'd1;
    localparam logic [1:0] TRK_DEATH = 2'd2;
    localparam logic [1:0] TRK_INTRO = 2'd3;

    localparam int          DEF_GAP_CYCLES     = 4;
    localparam logic [27:0] DEF_TIMEOUT_CYCLES = 28'd250_000_000;

endpackage

// File: rtl/music_sched_prio_enc4.sv
// rtl/music_sched_prio_enc4.sv - combinational highest-set-bit encoder for four requesters
module prio_enc4 (
    input  logic [3:0] req_i,
    output logic [1:0] winner_o,
    output logic       any_o
);

    always_comb begin
        winner_o = 2'd0;
        if (req_i[3])      winner_o = 2'd3;
        else if (req_i[2]) winner_o = 2'd2;
        else if (req_i[1]) winner_o = 2'd1;
        any_o = |req_i;
    end

endmodule

// File: rtl/music_sched.sv
// rtl/music_sched.sv - priority scheduler that sequences track requests into the buzzer player
module music_sched
    import music_sched_pkg::*;
#(
    parameter int          NTRK           = 4,
    parameter int          GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter logic [27:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NTRK-1:0] req,
    input  logic            mute,
    input  logic            music_interrupt,
    output logic [1:0]      music_select,
    output logic            music_start,
    output logic            busy,
    output logic [NTRK-1:0] pending,
    output logic            done
);

    sched_state_e    state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic            start_q, start_d;
    logic            done_q, done_d;
    logic [NTRK-1:0] pend_q, pend_d;
    logic [7:0]      gap_q, gap_d;
    logic [27:0]     play_q, play_d;

    logic [1:0]      winner;
    logic            any_pend;
    logic [NTRK-1:0] pend_set;
    logic            preempt;

    prio_enc4 u_prio (
        .req_i    (pend_q),
        .winner_o (winner),
        .any_o    (any_pend)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        start_d  = 1'b0;
        done_d   = 1'b0;
        gap_d    = gap_q;
        play_d   = play_q;
        preempt  = 1'b0;
        pend_set = req & {NTRK{~mute}};

        // A request for the track already on the speaker coalesces into it.
        if (state_q == ST_START || state_q == ST_PLAY)
            pend_set[sel_q] = 1'b0;
        pend_d = pend_q | pend_set;

        for (int i = 0; i < NTRK; i++)
            if (pend_q[i] && (i > int'(sel_q)))
                preempt = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (mute) begin
                    pend_d = '0;
                end else if (any_pend) begin
                    sel_d          = winner;
                    pend_d[winner] = 1'b0;
                    state_d        = ST_START;
                end
            end
            ST_START: begin
                if (mute) begin
                    pend_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    start_d = 1'b1;
                    play_d  = '0;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                start_d = 1'b1;
                play_d  = play_q + 28'd1;
                if (mute) begin
                    pend_d  = '0;
                    start_d = 1'b0;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (music_interrupt || play_q == TIMEOUT_CYCLES - 28'd1) begin
                    done_d  = 1'b1;
                    start_d = 1'b0;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (preempt) begin
                    start_d = 1'b0;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (mute) begin
                    pend_d  = '0;
                    state_d = ST_IDLE;
                end else if (gap_q == 8'(GAP_CYCLES - 1)) begin
                    if (any_pend) begin
                        sel_d          = winner;
                        pend_d[winner] = 1'b0;
                        state_d        = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= '0;
            gap_q   <= '0;
            play_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
            play_q  <= play_d;
        end
    end

    assign music_select = sel_q;
    assign music_start  = start_q;
    assign done         = done_q;
    assign pending      = pend_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_music_sched.sv
// tb/tb_music_sched.sv - directed self-checking bench for music_sched
module tb_music_sched;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] req;
    logic       mute;
    logic       music_interrupt;
    logic [1:0] music_select;
    logic       music_start;
    logic       busy;
    logic [3:0] pending;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    music_sched #(
        .NTRK           (4),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (28'd100)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .req             (req),
        .mute            (mute),
        .music_interrupt (music_interrupt),
        .music_select    (music_select),
        .music_start     (music_start),
        .busy            (busy),
        .pending         (pending),
        .done            (done)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] sel, input logic st,
                             input logic bsy, input logic [3:0] pnd, input logic dn);
        check({tag, ".select"},  32'(music_select), 32'(sel));
        check({tag, ".start"},   32'(music_start),  32'(st));
        check({tag, ".busy"},    32'(busy),         32'(bsy));
        check({tag, ".pending"}, 32'(pending),      32'(pnd));
        check({tag, ".done"},    32'(done),         32'(dn));
    endtask

    // Pulse req for one cycle, then walk through pending and START into PLAY.
    task automatic launch(input logic [3:0] r, input logic [1:0] trk);
        req = r;
        tick();
        req = 4'b0000;
        tick();
        check("launch.start_sel", 32'(music_select), 32'(trk));
        tick();
        check("launch.playing", 32'(music_start), 32'd1);
    endtask

    initial begin
        rstn            = 1'b0;
        req             = 4'b0000;
        mute            = 1'b0;
        music_interrupt = 1'b0;
        tick(2);
        check_all("reset", 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
        rstn = 1'b1;

        // Single request: pending, START, then PLAY.
        req = 4'b0001;
        tick();
        req = 4'b0000;
        check_all("t1.pend", 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0);
        tick();
        check_all("t1.start", 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0);
        tick();
        check_all("t1.play", 2'd0, 1'b1, 1'b1, 4'b0000, 1'b0);
        tick(3);

        // Normal end: one-cycle done, four-cycle gap, back to idle.
        music_interrupt = 1'b1;
        tick();
        music_interrupt = 1'b0;
        check_all("t2.gap0", 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1);
        tick();
        check_all("t2.gap1", 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0);
        tick(2);
        check_all("t2.gap3", 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0);
        tick();
        check_all("t2.idle", 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

        // Preempt track 1 with track 3.
        launch(4'b0010, 2'd1);
        tick();
        req = 4'b1000;
        tick();
        req = 4'b0000;
        check_all("t3.pend", 2'd1, 1'b1, 1'b1, 4'b1000, 1'b0);
        tick();
        check_all("t3.gap0", 2'd1, 1'b0, 1'b1, 4'b1000, 1'b0);
        tick(3);
        check_all("t3.gap3", 2'd1, 1'b0, 1'b1, 4'b1000, 1'b0);
        tick();
        check_all("t3.start", 2'd3, 1'b0, 1'b1, 4'b0000, 1'b0);
        tick();
        check_all("t3.play", 2'd3, 1'b1, 1'b1, 4'b0000, 1'b0);
        music_interrupt = 1'b1;
        tick();
        music_interrupt = 1'b0;
        check("t3.done", 32'(done), 32'd1);
        tick(4);
        check_all("t3.noreplay", 2'd3, 1'b0, 1'b0, 4'b0000, 1'b0);

        // Coalescing: req for the playing track is dropped, lower one waits.
        launch(4'b0100, 2'd2);
        req = 4'b0101;
        tick();
        req = 4'b0000;
        check_all("t4.coalesce", 2'd2, 1'b1, 1'b1, 4'b0001, 1'b0);
        tick(2);
        check_all("t4.noprempt", 2'd2, 1'b1, 1'b1, 4'b0001, 1'b0);
        music_interrupt = 1'b1;
        tick();
        music_interrupt = 1'b0;
        check_all("t4.gap0", 2'd2, 1'b0, 1'b1, 4'b0001, 1'b1);
        tick(3);
        check_all("t4.gap3", 2'd2, 1'b0, 1'b1, 4'b0001, 1'b0);
        tick();
        check_all("t4.start", 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0);
        tick();
        check("t4.play", 32'(music_start), 32'd1);
        music_interrupt = 1'b1;
        tick();
        music_interrupt = 1'b0;
        tick(4);
        check("t4.idle", 32'(busy), 32'd0);

        // Timeout after exactly 100 PLAY cycles.
        launch(4'b0001, 2'd0);
        tick(99);
        check("t5.before", 32'(done), 32'd0);
        check("t5.stillplay", 32'(music_start), 32'd1);
        tick();
        check_all("t5.timeout", 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1);
        tick();
        check("t5.pulse", 32'(done), 32'd0);
        tick(3);
        check("t5.idle", 32'(busy), 32'd0);

        // Mute mid-PLAY with a lower request pending.
        launch(4'b0100, 2'd2);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        check("t6.pend", 32'(pending), 32'h2);
        mute = 1'b1;
        tick();
        check_all("t6.mute", 2'd2, 1'b0, 1'b1, 4'b0000, 1'b0);
        req = 4'b1111;
        tick();
        check_all("t6.muteidle", 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick();
        check("t6.ignored", 32'(pending), 32'h0);
        mute = 1'b0;
        req  = 4'b0000;
        tick();

        // Reset mid-PLAY with a pending request.
        launch(4'b0010, 2'd1);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        check("t7.pend", 32'(pending), 32'h1);
        rstn = 1'b0;
        tick();
        check_all("t7.reset", 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
        rstn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/music_sched.md
Name: music_sched

Overview:
- Sound-request scheduler placed in front of the buzzer music player.
- Game logic raises per-track requests (pellet, ghost eaten, death, intro). The block latches them and grants the highest-priority one.
- It drives the player's track select and start level, and uses the player's end-of-track pulse to sequence the next track.
- Higher-priority requests preempt the playing track. A guaranteed low gap restarts the player cleanly between tracks.

Parameters:
- NTRK, 4: number of tracks/requesters; equals the width of the player's 2-bit select space.
- GAP_CYCLES, 4: cycles music_start is held low between tracks; legal range 1..255.
- TIMEOUT_CYCLES, 28'd250_000_000: maximum PLAY duration (5 s at 50 MHz) before forced end; 28-bit.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; one clock; reset is synchronous and active-low
- req  in  4  per-track request; level-sampled every cycle; bit i = track i; priority i (3 highest)
- mute  in  1  while high: abort playback, clear pending, ignore req
- music_interrupt  in  1  end-of-track pulse from the player
- music_select  out  2  track ID to the player; registered
- music_start  out  1  player enable level; registered
- busy  out  1  state != IDLE
- pending  out  4  latched, not-yet-granted requests
- done  out  1  one-cycle pulse when a track ends normally or times out (not on preempt or mute)

Behaviour:
- Reset, synchronous on rstn==0 at a clk edge:
  - state=IDLE; music_select=0; music_start=0; busy=0; pending=0; done=0; gap_cnt=0; play_cnt=0.
- Pending latch:
  - pending[i] <= 1 when req[i]==1 and mute==0.
  - pending[i] is cleared at the edge where track i is granted.
  - A req for the currently playing track is dropped (coalesced).
- Grant: winner = highest set index of pending.
- State machine: states IDLE, START, PLAY, GAP.
  - IDLE: music_start=0. If pending!=0: music_select<=winner, clear pending[winner], go to START.
  - START: one cycle; music_start=0 with select stable; go to PLAY. music_start=1 from the first PLAY cycle.
  - PLAY: music_start=1; play_cnt increments from 0. Exit conditions, checked in this priority order:
    - mute: go to GAP, pending cleared, no done.
    - music_interrupt: done=1 for one cycle, go to GAP.
    - play_cnt==TIMEOUT_CYCLES-1: done=1, go to GAP.
    - any pending[j] with j>music_select (preempt): go to GAP, no done. The preempted track is not re-queued.
    - Lower- or equal-priority requests stay pending.
  - GAP: music_start=0; gap_cnt counts 0..GAP_CYCLES-1.
    - At terminal count: if pending!=0 and mute==0, grant as in IDLE and go to START; else go to IDLE.
    - music_select holds the old value until the grant.
- Latency:
  - req high at edge n → pending at n+1 → START (select updated) at n+2 → music_start=1 at n+3.
  - Track end to next music_start: GAP_CYCLES+2 cycles.
- music_interrupt outside PLAY is ignored.
- Simultaneous interrupt and preempt: done asserted, then the preemptor is granted after the gap.
- mute in IDLE/START/GAP: clear pending, go to (or stay in) IDLE, music_start=0.
- Reset mid-PLAY: all outputs to reset values at the next edge.
- Counters saturate-free: both counters are cleared on state entry.

Decomposition:
- Package music_sched_pkg:
  - state encoding (2-bit localparams);
  - track ID constants TRK_WAKA=0, TRK_GHOST=1, TRK_DEATH=2, TRK_INTRO=3;
  - default GAP/TIMEOUT constants.
- One sub-module, prio_enc4: combinational highest-set-bit encoder producing winner[1:0] and any.

Test Plan:
- Reset, then req=4'b0001 for 1 cycle → pending=0001 at n+1; music_select=0 at n+2; music_start=1 at n+3; busy=1; pending=0.
- While track 0 plays, pulse music_interrupt → done=1 for exactly 1 cycle; music_start=0 for GAP_CYCLES=4 cycles; then IDLE with busy=0.
- Track 1 playing, req[3] pulses → music_start drops next cycle, no done, 4-cycle gap; music_select=3 in START; music_start=1 after it; track 1 not replayed.
- Track 2 playing, req[0] and req[2] pulse → pending=0001 (req[2] coalesced); on interrupt: done, gap, then track 0 granted.
- TIMEOUT_CYCLES=100 override, no interrupt → done pulse at PLAY cycle 100, then GAP.
- mute asserted mid-PLAY with pending=0010 → music_start=0 and pending=0 next cycle, no done; req ignored while mute=1; rstn low mid-PLAY → all outputs zero after one edge.
